// File: rtl/gate_mux2_if.sv
// gate_mux2_if: packed data, select and load enable in; combinational and registered mux results out.
interface gate_mux2_if #(parameter int WIDTH = 1);
   logic [2*WIDTH-1:0] in;
   logic               sel;
   logic               en;
   logic [WIDTH-1:0]   out;
   logic [WIDTH-1:0]   out_q;
   modport master (output in, sel, en, input out, out_q);
   modport slave (input in, sel, en, output out, out_q);
endinterface

// File: rtl/gate_mux2.sv
// gate_mux2: gate-level 2:1 mux (one shared sel inverter, AND pair + OR per bit) with an enabled output register.
module gate_mux2 #(parameter int WIDTH = 1) (
   input logic        clk,
   input logic        rst_n,
   gate_mux2_if.slave bus
);
   logic             sel_n;
   logic [WIDTH-1:0] and0;
   logic [WIDTH-1:0] and1;
   logic [WIDTH-1:0] mux;
   logic [WIDTH-1:0] out_q_d;
   logic [WIDTH-1:0] out_q_q;
   genvar i;
   not u_inv (sel_n, bus.sel);
   for (i = 0; i < WIDTH; i++) begin : g_bit
      and u_a0 (and0[i], bus.in[i], sel_n);
      and u_a1 (and1[i], bus.in[WIDTH+i], bus.sel);
      or  u_or (mux[i], and0[i], and1[i]);
   end
   always_comb out_q_d = bus.en ? mux : out_q_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) out_q_q <= '0;
      else out_q_q <= out_q_d;
   assign bus.out   = mux;
   assign bus.out_q = out_q_q;
endmodule

// File: tb/tb_gate_mux2.sv
// tb_gate_mux2: directed vectors on WIDTH=1 and WIDTH=8 instances, checked against a select/hold model every cycle.
module tb_gate_mux2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic run = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic       m1;
   logic [7:0] m8;
   logic [7:0] sweep_exp;
   always #5 clk = ~clk;
   gate_mux2_if #(.WIDTH(1)) b1 ();
   gate_mux2_if #(.WIDTH(8)) b8 ();
   gate_mux2 #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   gate_mux2 #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   function automatic logic pick1(logic [1:0] v, logic s);
      return s ? v[1] : v[0];
   endfunction
   function automatic logic [7:0] pick8(logic [15:0] v, logic s);
      return s ? v[15:8] : v[7:0];
   endfunction
   // Register model: cleared whenever reset is low, otherwise takes the selected input on enabled edges.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m1 <= 1'b0;
         m8 <= 8'h00;
      end else begin
         if (b1.en) m1 <= pick1(b1.in, b1.sel);
         if (b8.en) m8 <= pick8(b8.in, b8.sel);
      end
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk)
      if (run) begin
         check("cyc_out1", {7'd0, b1.out}, {7'd0, pick1(b1.in, b1.sel)});
         check("cyc_outq1", {7'd0, b1.out_q}, {7'd0, m1});
         check("cyc_out8", b8.out, pick8(b8.in, b8.sel));
         check("cyc_outq8", b8.out_q, m8);
      end
   initial begin
      b1.in = 2'b00; b1.sel = 1'b0; b1.en = 1'b1;
      b8.in = {8'hA5, 8'h3C}; b8.sel = 1'b1; b8.en = 1'b1;
      #1;
      check("rst_outq1", {7'd0, b1.out_q}, 8'h00);
      check("rst_outq8", b8.out_q, 8'h00);
      check("rst_out8_valid", b8.out, 8'hA5);
      @(posedge clk); #1;
      check("rst_outq8_clk", b8.out_q, 8'h00);
      @(negedge clk); #1;
      rst_n = 1'b1;
      run = 1'b1;
      #100;
      check("idle_out0", {7'd0, b1.out}, 8'h00);
      b1.in = 2'b10; b1.sel = 1'b1; #1;
      check("sel1_out1", {7'd0, b1.out}, 8'h01);
      b1.sel = 1'b0; #1;
      check("sel0_out0", {7'd0, b1.out}, 8'h00);
      b1.in = 2'b01; b1.sel = 1'b0; #1;
      check("sel0_in0hi", {7'd0, b1.out}, 8'h01);
      b1.sel = 1'b1; #1;
      check("sel1_in0hi", {7'd0, b1.out}, 8'h00);
      sweep_exp = 8'b1110_0100;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         b1.in = k[2:1]; b1.sel = k[0]; #1;
         check("sweep_out", {7'd0, b1.out}, {7'd0, sweep_exp[k]});
         @(posedge clk); #1;
         check("sweep_outq", {7'd0, b1.out_q}, {7'd0, sweep_exp[k]});
      end
      @(negedge clk); #1;
      b1.in = 2'b10; b1.sel = 1'b1;
      @(posedge clk); #1;
      check("load_one", {7'd0, b1.out_q}, 8'h01);
      #2 rst_n = 1'b0; #1;
      check("async_clr", {7'd0, b1.out_q}, 8'h00);
      check("rst_out_kept", {7'd0, b1.out}, 8'h01);
      @(posedge clk); #1;
      check("rst_hold_edge", {7'd0, b1.out_q}, 8'h00);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reload_after_rst", {7'd0, b1.out_q}, 8'h01);
      @(negedge clk); #1;
      b1.en = 1'b0;
      for (int j = 0; j < 3; j++) begin
         b1.in = (j == 0) ? 2'b01 : (j == 1) ? 2'b10 : 2'b00;
         b1.sel = (j != 1);
         @(posedge clk); #1;
         check("en0_hold", {7'd0, b1.out_q}, 8'h01);
         check("en0_out_zero", {7'd0, b1.out}, 8'h00);
         @(negedge clk); #1;
      end
      b1.en = 1'b1;
      b8.sel = 1'b1; #1;
      check("w8_sel1", b8.out, 8'hA5);
      b8.sel = 1'b0; #1;
      check("w8_sel0", b8.out, 8'h3C);
      @(posedge clk); #1;
      check("w8_outq", b8.out_q, 8'h3C);
      @(negedge clk); #1;
      b8.in = {8'h5A, 8'h5A}; b8.sel = 1'b1; #1;
      check("w8_equal_sel1", b8.out, 8'h5A);
      b8.sel = 1'b0; #1;
      check("w8_equal_sel0", b8.out, 8'h5A);
      b8.in = {8'hF0, 8'h0F}; b8.sel = 1'b1;
      b8.en = 1'b0;
      @(posedge clk); #1;
      check("w8_en0_hold", b8.out_q, 8'h3C);
      @(negedge clk); #1;
      b8.en = 1'b1;
      @(posedge clk); #1;
      check("w8_en1_load", b8.out_q, 8'hF0);
      @(negedge clk); #1;
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gate_mux2.md
Name: gate_mux2

Overview:
- Gate-level structural 2:1 multiplexer with a combinational select path and a registered copy of the result.
- Used as a leaf datapath primitive wherever a two-way select is needed.
- The combinational output `out` is available in the same cycle.
- The registered output `out_q` gives a one-cycle-delayed, reset-clean version for timing-critical consumers.

Parameters:
- WIDTH, 1, bit width of each data input and of each output.

Ports:
- clk  input  1  rising-edge clock; used only by the output register.
- rst_n  input  1  asynchronous active-low reset; clears the output register.
- in  input  2*WIDTH  packed data.
  - in[WIDTH-1:0] is input 0.
  - in[2*WIDTH-1:WIDTH] is input 1.
- sel  input  1  select: 0 chooses input 0, 1 chooses input 1.
- en  input  1  load enable for out_q. Tie high for a plain pipeline register.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result.

Behaviour:
- Combinational path, per bit i:
  - out[i] = (in[i] AND NOT sel) OR (in[WIDTH+i] AND sel).
  - Built from NOT/AND/OR gate primitives only, replicated per bit with a generate loop. No behavioural ?: or case on this path.
  - Single shared inverter on sel; one AND pair and one OR per bit.
  - out has zero clock latency and is independent of clk, rst_n and en.
  - out follows any change on in or sel after gate delay only.
  - out is valid during reset.
- Registered path:
  - On rising clk with rst_n=1 and en=1, out_q <= out, i.e. the value of the mux at that edge.
  - With en=0, out_q holds its value.
  - Latency is 1 clock from an in/sel change to out_q.
- Reset:
  - rst_n low clears out_q to all zeros immediately, asynchronously, without waiting for clk.
  - out_q stays zero while rst_n is low, regardless of clk or en.
  - On deassertion, the first rising edge with en=1 loads the current mux value.
  - Reset asserted mid-operation discards the held value.
  - The combinational out is unaffected by reset.
- Boundary conditions:
  - sel changing in the same cycle as the data: the value sampled at the clk edge is the fully settled combination.
  - Both inputs equal: out equals that value for either sel.
  - X/Z on sel:
    - the gate structure yields X on any bit where the two inputs differ;
    - bits where the inputs are equal resolve to the common value when the inputs are 0, per primitive semantics.
    - No masking logic is added.
- Widths: no arithmetic; all paths are exactly WIDTH bits; no truncation or extension.

Test Plan:
- WIDTH=1, rst_n=1: in=2'b00, sel=0 -> out=0. Hold 100 ns.
- in[0]=0, in[1]=1, sel=1 -> out=1 within gate delay, no clock needed. Then sel=0 -> out=0.
- in[0]=1, in[1]=0, sel=0 -> out=1. Then sel=1 -> out=0.
- Exhaustive 8-combination sweep of {in[1],in[0],sel} -> out matches the selected input each time. out_q matches out one rising clk later with en=1.
- out_q loaded to 1, then rst_n driven low between clock edges -> out_q=0 immediately. out unchanged. After release, first edge with en=1 reloads the mux value.
- en=0 with changing in/sel over 3 clocks -> out_q holds. WIDTH=8 instance: in={8'hA5,8'h3C}, sel=1 -> out=8'hA5; sel=0 -> out=8'h3C.
